pkt_encoder_param: RTL and testbench

Parametrised next-generation packet encoder. Accepts a destination address, a payload length and a burst of payload words, and buffers the payload internally. It then emits a framed packet: address, length, payload, then an XOR parity word. Adds output backpressure, configurable width/depth and error reporting; it sits between a payload source and the downstream link/router input.

---
 rtl/pkt_enc_pkg.sv | 20 ++
 rtl/pkt_buf.sv | 28 ++
 rtl/pkt_encoder_param.sv | 176 +++++++++++++++++
 tb/tb_pkt_encoder_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_enc_pkg.sv
// Shared types for the packet encoder: FSM state encoding and error codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_enc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        LEN,
        PAY,
        PAR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ZERO     = 2'b01;
    localparam logic [1:0] ERR_OVERSIZE = 2'b10;
    localparam logic [1:0] ERR_SHORT    = 2'b11;

endpackage

// File: rtl/pkt_buf.sv
// Payload store: DEPTH x DW words, one write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr_i combinationally.
// Backpressure: none; the owner decides when to write and what to read.
module pkt_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdat_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdat_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage is never reset: every word read in a packet was written in that packet.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/pkt_encoder_param.sv
// Packet encoder: buffers N payload words, then emits addr, N, payload, XOR parity.
// Latency: header is valid the cycle after the last payload word is taken; N+3 output words.
// Backpressure: each output word holds until out_ready; no input is taken while emitting.
module pkt_encoder_param
    import pkt_enc_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MAX_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ip_valid,
    output logic          in_ready,
    input  logic [DW-1:0] destination_addr,
    input  logic [DW-1:0] payload_size,
    input  logic [DW-1:0] payload_din,
    output logic [DW-1:0] packet_out,
    output logic          packet_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          err_valid,
    output logic [1:0]    err_code
);

    // A single-entry buffer still needs a one-bit pointer.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] size_q, size_d;
    logic [DW-1:0] par_q, par_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          err_vld_q, err_vld_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_rdat;

    pkt_buf #(
        .DW    (DW),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdat_i  (payload_din),
        .raddr_i (rptr_q),
        .rdat_o  (buf_rdat)
    );

    // Next-state, handshake and output word selection.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        par_d        = par_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        err_vld_d    = 1'b0;
        err_code_d   = err_code_q;
        buf_we       = 1'b0;
        buf_waddr    = wptr_q;
        in_ready     = 1'b0;
        packet_valid = 1'b0;
        packet_out   = '0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (ip_valid) begin
                    // First beat carries header fields and payload word 0 together.
                    addr_d    = destination_addr;
                    size_d    = payload_size;
                    par_d     = destination_addr ^ payload_size ^ payload_din;
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    wptr_d    = AW'(1);
                    rptr_d    = '0;
                    if (payload_size == '0) begin
                        err_vld_d  = 1'b1;
                        err_code_d = ERR_ZERO;
                    end else if (payload_size > DW'(MAX_LEN)) begin
                        err_vld_d  = 1'b1;
                        err_code_d = ERR_OVERSIZE;
                    end else if (payload_size == DW'(1)) begin
                        state_d = HDR;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (ip_valid) begin
                    buf_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    par_d  = par_q ^ payload_din;
                    if (DW'(wptr_q) == size_q - DW'(1)) begin
                        state_d = HDR;
                    end
                end else begin
                    // Payload must be gap-free; a hole drops the whole packet.
                    err_vld_d  = 1'b1;
                    err_code_d = ERR_SHORT;
                    state_d    = IDLE;
                end
            end
            HDR: begin
                packet_valid = 1'b1;
                packet_out   = addr_q;
                if (out_ready) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                packet_valid = 1'b1;
                packet_out   = size_q;
                if (out_ready) begin
                    state_d = PAY;
                end
            end
            PAY: begin
                packet_valid = 1'b1;
                packet_out   = buf_rdat;
                if (out_ready) begin
                    if (DW'(rptr_q) == size_q - DW'(1)) begin
                        state_d = PAR;
                    end else begin
                        rptr_d = rptr_q + AW'(1);
                    end
                end
            end
            PAR: begin
                packet_valid = 1'b1;
                packet_out   = par_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            par_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            par_q      <= par_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign err_valid = err_vld_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_pkt_encoder_param.sv
// Bench for pkt_encoder_param: an 8-bit/32-deep and a 16-bit/4-deep instance.
// Latency: expected frames come from a queue model built from the framing rules.
// Backpressure: out_ready is driven steady, patterned or random per cycle.
module tb_pkt_encoder_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ipv8, ipv16, out_ready;
    logic [15:0] addr, size, din;

    logic        inr8, vld8, busy8, errv8;
    logic [7:0]  pout8;
    logic [1:0]  errc8;
    logic        inr16, vld16, busy16, errv16;
    logic [15:0] pout16;
    logic [1:0]  errc16;

    pkt_encoder_param #(.DW(8), .MAX_LEN(32)) dut8 (
        .clk(clk), .rst(rst), .ip_valid(ipv8), .in_ready(inr8),
        .destination_addr(addr[7:0]), .payload_size(size[7:0]), .payload_din(din[7:0]),
        .packet_out(pout8), .packet_valid(vld8), .out_ready(out_ready),
        .busy(busy8), .err_valid(errv8), .err_code(errc8)
    );

    pkt_encoder_param #(.DW(16), .MAX_LEN(4)) dut16 (
        .clk(clk), .rst(rst), .ip_valid(ipv16), .in_ready(inr16),
        .destination_addr(addr), .payload_size(size), .payload_din(din),
        .packet_out(pout16), .packet_valid(vld16), .out_ready(out_ready),
        .busy(busy16), .err_valid(errv16), .err_code(errc16)
    );

    int          checks = 0;
    int          fails  = 0;
    bit          sel;            // 0: 8-bit instance, 1: 16-bit instance
    logic [15:0] pl [64];
    logic [15:0] expq [$];

    function automatic logic [15:0] o_out();  return sel ? pout16 : {8'h00, pout8}; endfunction
    function automatic logic        o_vld();  return sel ? vld16  : vld8;  endfunction
    function automatic logic        o_busy(); return sel ? busy16 : busy8; endfunction
    function automatic logic        o_inr();  return sel ? inr16  : inr8;  endfunction
    function automatic logic        o_errv(); return sel ? errv16 : errv8; endfunction
    function automatic logic [1:0]  o_errc(); return sel ? errc16 : errc8; endfunction
    function automatic logic [15:0] mask();   return sel ? 16'hFFFF : 16'h00FF; endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_vld"},  16'(o_vld()),  16'd0);
        chk({tag, "_busy"}, 16'(o_busy()), 16'd0);
        chk({tag, "_inr"},  16'(o_inr()),  16'd1);
    endtask

    // Present beats 0..beats-1 from pl[] on consecutive cycles.
    task automatic drive(input logic [15:0] a, input logic [15:0] n, input int beats);
        for (int i = 0; i < beats; i++) begin
            chk("in_ready", 16'(o_inr()), 16'd1);
            addr = a; size = n; din = pl[i];
            if (sel) ipv16 = 1'b1; else ipv8 = 1'b1;
            step();
        end
        ipv8 = 1'b0; ipv16 = 1'b0;
        addr = 16'($urandom); size = 16'($urandom); din = 16'($urandom);
    endtask

    // Reference frame: address, count, payload, then XOR of everything before it.
    task automatic model(input logic [15:0] a, input logic [15:0] n);
        logic [15:0] p;
        expq.delete();
        expq.push_back(a & mask());
        expq.push_back(n & mask());
        p = (a ^ n) & mask();
        for (int i = 0; i < int'(n & mask()); i++) begin
            expq.push_back(pl[i] & mask());
            p = p ^ (pl[i] & mask());
        end
        expq.push_back(p);
    endtask

    // stall: 0 always ready, 1 random, 2 pattern 1,0,0. rst_at: frame index to reset at.
    task automatic collect(input int stall, input int rst_at);
        int idx = 0;
        int cyc = 0;
        int budget = 2000;
        while (idx < expq.size() && budget > 0) begin
            budget--;
            case (stall)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc % 3 == 0);
            endcase
            cyc++;
            if (idx > 0 && stall == 0) chk("no_gap", 16'(o_vld()), 16'd1);
            if (o_vld()) begin
                if (idx == rst_at) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    idle_checks("after_rst");
                    chk("after_rst_out", o_out(), 16'd0);
                    out_ready = 1'b1;
                    return;
                end
                chk("pkt_word", o_out(), expq[idx]);
                if (out_ready) idx++;
            end
            step();
        end
        chk("frame_len", 16'(idx), 16'(expq.size()));
        idle_checks("post_frame");
        out_ready = 1'b1;
    endtask

    task automatic rand_packet(input int maxn, input int stall);
        logic [15:0] a, n;
        a = 16'($urandom);
        n = 16'($urandom_range(1, maxn));
        for (int i = 0; i < 64; i++) pl[i] = 16'($urandom);
        drive(a, n, int'(n));
        model(a, n);
        collect(stall, -1);
    endtask

    task automatic load_t1();
        pl[0] = 16'h11; pl[1] = 16'h22; pl[2] = 16'h33; pl[3] = 16'h44; pl[4] = 16'h55;
    endtask

    initial begin
        rst = 1'b1; ipv8 = 1'b0; ipv16 = 1'b0; out_ready = 1'b1;
        addr = '0; size = '0; din = '0; sel = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            idle_checks("reset");
            chk("reset_out",  o_out(), 16'd0);
            chk("reset_errv", 16'(o_errv()), 16'd0);
            chk("reset_errc", 16'(o_errc()), 16'd0);
        end
        sel = 1'b0;

        // Basic frame, continuous ready.
        load_t1();
        drive(16'hAA, 16'd5, 5);
        model(16'hAA, 16'd5);
        chk("t1_parity_word", expq[7], 16'hBE);
        collect(0, -1);

        // Same frame with 1,0,0 ready pattern.
        load_t1();
        drive(16'hAA, 16'd5, 5);
        model(16'hAA, 16'd5);
        collect(2, -1);

        // Zero length, then oversize.
        drive(16'hAA, 16'd0, 1);
        chk("zero_errv", 16'(o_errv()), 16'd1);
        chk("zero_errc", 16'(o_errc()), 16'd1);
        idle_checks("zero");
        step();
        chk("zero_pulse_end", 16'(o_errv()), 16'd0);
        chk("zero_sticky",    16'(o_errc()), 16'd1);
        drive(16'hAA, 16'h21, 1);
        chk("over_errv", 16'(o_errv()), 16'd1);
        chk("over_errc", 16'(o_errc()), 16'd2);
        idle_checks("over");

        // Short burst, then a single-word packet.
        for (int i = 0; i < 64; i++) pl[i] = 16'($urandom);
        drive(16'hCC, 16'd6, 3);
        step();
        chk("short_errv", 16'(o_errv()), 16'd1);
        chk("short_errc", 16'(o_errc()), 16'd3);
        for (int i = 0; i < 4; i++) begin
            idle_checks("short_quiet");
            step();
        end
        pl[0] = 16'h66;
        drive(16'hBB, 16'd1, 1);
        model(16'hBB, 16'd1);
        chk("t4_parity_word", expq[3], 16'hDC);
        collect(0, -1);
        chk("short_sticky", 16'(o_errc()), 16'd3);

        // Reset while emitting payload word 2, then a clean frame.
        load_t1();
        drive(16'hAA, 16'd5, 5);
        model(16'hAA, 16'd5);
        collect(0, 4);
        chk("rst_errc", 16'(o_errc()), 16'd0);
        load_t1();
        drive(16'hAA, 16'd5, 5);
        model(16'hAA, 16'd5);
        collect(1, -1);

        // Full-depth packet.
        for (int i = 0; i < 64; i++) pl[i] = 16'($urandom);
        drive(16'h5A, 16'd32, 32);
        model(16'h5A, 16'd32);
        collect(1, -1);

        // Random 8-bit traffic.
        for (int k = 0; k < 12; k++) rand_packet(32, k % 3);

        // 16-bit instance: directed, oversize, random.
        sel = 1'b1;
        pl[0] = 16'h0001; pl[1] = 16'h0002; pl[2] = 16'h0003; pl[3] = 16'h0004;
        drive(16'h1234, 16'h0004, 4);
        model(16'h1234, 16'h0004);
        collect(0, -1);
        drive(16'h1234, 16'h0005, 1);
        chk("w16_over_errc", 16'(o_errc()), 16'd2);
        idle_checks("w16_over");
        for (int k = 0; k < 6; k++) rand_packet(4, k % 3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
